// File: rtl/ex_pkg.sv
// ex_pkg: types and constants shared by the EX-stage multiply/divide sequencer.
//   muldiv_op_t : operation select presented by ID/EX (NOP, MUL, DIVU, REMU)
//   state_t     : sequencer states (IDLE, RUN, DONE)
//   MULDIV_ITER : iterations per operation, one result bit per cycle
//   is_div_op   : true for DIVU and REMU, the two ops sharing the divider
package ex_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'b00,
    MUL  = 2'b01,
    DIVU = 2'b10,
    REMU = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MULDIV_ITER = 32;

  // Both divide flavours have the upper op bit set, so this is the
  // divider-vs-multiplier decision everywhere in the design.
  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shared shift registers, adder/subtractor and iteration
// counter for the iterative unsigned multiply and restoring divide.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture operands and clear counter/accumulator
//   step       : perform one iteration this cycle
//   is_div     : operation being loaded is a divide (DIVU/REMU)
//   val1, val2 : multiplicand/multiplier or dividend/divisor
//   last       : the current iteration is the final one
//   step_lo    : low word after this iteration (product low / quotient)
//   step_rem   : high word after this iteration (remainder for divides)
module muldiv_datapath
  import ex_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITER,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  output logic             last,
  output logic [WIDTH-1:0] step_lo,
  output logic [WIDTH-1:0] step_rem
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic [CNT_W-1:0] cnt;
  logic             div_mode;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // One iteration of either algorithm, computed from the current registers.
  // Multiply: {hi,lo} is the 2*WIDTH product register with the multiplier in
  // lo; when its LSB is set the multiplicand is added into hi, then the whole
  // register shifts right one place, so after WIDTH steps lo is the low word.
  // Divide: the partial remainder in hi is shifted left taking in the next
  // dividend bit from lo's MSB, forming a WIDTH+1 bit trial remainder. If the
  // divisor fits it is subtracted and a 1 shifts into lo's LSB, otherwise a 0
  // does. The difference can be taken in WIDTH bits because whenever the
  // divisor fits the result is below the divisor.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    trial   = {hi, lo[WIDTH-1]};
    fits    = (trial >= {1'b0, opnd});
    diff    = trial[WIDTH-1:0] - opnd;
    if (div_mode) begin
      lo_nxt = {lo[WIDTH-2:0], fits};
      hi_nxt = fits ? diff : trial[WIDTH-1:0];
    end else begin
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  assign step_lo  = lo_nxt;
  assign step_rem = hi_nxt;
  assign last     = (cnt == CNT_W'(WIDTH - 1));

  // Operand capture and per-cycle advance. The multiplier and the dividend
  // both live in lo because both algorithms consume that word one bit per
  // cycle; opnd holds whichever value is added or subtracted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      cnt      <= '0;
      div_mode <= 1'b0;
    end else if (load) begin
      hi       <= '0;
      cnt      <= '0;
      div_mode <= is_div;
      if (is_div) begin
        lo   <= val1;
        opnd <= val2;
      end else begin
        lo   <= val2;
        opnd <= val1;
      end
    end else if (step) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: iterative multiply/divide sequencer in the EX stage.
// Accepts one op from ID/EX, stalls the pipeline front while it iterates and
// presents result/dest/wb_en for one cycle in place of the ALU output.
//   clk, rst          : clock, asynchronous active-high reset
//   start, op         : ID/EX holds a mul/div instruction, and which one
//   val1, val2        : forwarded operands
//   dest_in, wb_en_in : destination register and write-back enable
//   flush             : branch-taken flush
//   stall             : freeze IF, ID and ID/EX
//   busy              : sequencer is not idle
//   done              : result valid (one-cycle pulse)
//   result            : product low word, quotient or remainder
//   dest_out          : registered destination
//   wb_en_out         : registered write-back enable, gated by flush
module ex_muldiv_ctrl
  import ex_pkg::*;
#(
  parameter int WIDTH = MULDIV_ITER,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [4:0]       dest_in,
  input  logic             wb_en_in,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       dest_out,
  output logic             wb_en_out
);

  state_t     state;
  muldiv_op_t op_q;
  logic [4:0] dest_q;
  logic       wb_en_q;
  logic       done_q;
  logic       wb_out_q;

  logic             accept;
  logic             div_zero;
  logic             last;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] step_rem;

  // A new op can be taken from IDLE or from the DONE cycle (back-to-back);
  // start is ignored while running because ID/EX is frozen on the same op.
  assign accept   = start && (op != NOP) && !flush && (state != RUN);
  assign div_zero = is_div_op(op) && (val2 == '0);

  // Stall is combinational so the instruction is held from its very first EX
  // cycle; it is low in DONE so the pipeline advances and captures result.
  assign stall = !rst && ((state == IDLE && accept) || state == RUN);
  assign busy  = (state != IDLE);

  // A flush arriving in the DONE cycle kills the write-back of the result.
  assign done      = done_q && !flush;
  assign wb_en_out = wb_out_q && !flush;

  muldiv_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    (state == RUN),
    .is_div  (is_div_op(op)),
    .val1    (val1),
    .val2    (val2),
    .last    (last),
    .step_lo (step_lo),
    .step_rem(step_rem)
  );

  // Sequencer FSM with registered outputs. done/wb_en_out default low and are
  // raised only on the edge that enters DONE, which makes them a one-cycle
  // pulse. A divide by zero skips RUN entirely: quotient is all ones and the
  // remainder is the dividend. The final iteration's values are taken from
  // the datapath's next-state outputs so result is valid in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= NOP;
      dest_q   <= '0;
      wb_en_q  <= 1'b0;
      result   <= '0;
      dest_out <= '0;
      done_q   <= 1'b0;
      wb_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      wb_out_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            op_q    <= muldiv_op_t'(op);
            dest_q  <= dest_in;
            wb_en_q <= wb_en_in;
            if (div_zero) begin
              state    <= DONE;
              done_q   <= 1'b1;
              wb_out_q <= wb_en_in;
              dest_out <= dest_in;
              result   <= (op == REMU) ? val1 : '1;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else if (last) begin
            state    <= DONE;
            done_q   <= 1'b1;
            wb_out_q <= wb_en_q;
            dest_out <= dest_q;
            result   <= (op_q == REMU) ? step_rem : step_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// tb_ex_muldiv_ctrl: self-checking bench for ex_muldiv_ctrl. Directed cases
// from the test plan plus randomized ops, all checked against a plain
// arithmetic reference model of product/quotient/remainder and latency.
module tb_ex_muldiv_ctrl;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [4:0]  dest_in;
  logic        wb_en_in;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  dest_out;
  logic        wb_en_out;

  int checks = 0;
  int errors = 0;

  ex_muldiv_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .val1     (val1),
    .val2     (val2),
    .dest_in  (dest_in),
    .wb_en_in (wb_en_in),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dest_out (dest_out),
    .wb_en_out(wb_en_out)
  );

  // 10 time-unit clock; inputs change 1 unit after the rising edge and
  // outputs are sampled 2 units after it.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic longint modelResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'b01:   return longint'(p[31:0]);
      2'b10:   return (b == 0) ? longint'(32'hFFFF_FFFF) : longint'(a / b);
      2'b11:   return (b == 0) ? longint'(a) : longint'(a % b);
      default: return 0;
    endcase
  endfunction

  // Cycles from the accepting cycle to the done cycle.
  function automatic int modelLatency(input logic [1:0] o, input logic [31:0] b);
    return (o != 2'b01 && b == 0) ? 1 : 33;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one op (holding start while stalled, as a frozen ID/EX would),
  // waits for done with a bounded cycle budget and checks latency, stall
  // count, result, dest and wb_en. 'chained' means it is driven during the
  // previous op's DONE cycle; 'keep' leaves start high so the caller can
  // chain another op into this op's DONE cycle.
  task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] d, input logic w,
                               input bit chained, input bit keep);
    int cyc;
    int done_cyc;
    int stall_cnt;
    int lat;
    logic [31:0] r;
    logic [4:0]  dq;
    logic        wq;
    logic        st;
    lat = modelLatency(o, b);
    start = 1'b1; op = o; val1 = a; val2 = b; dest_in = d; wb_en_in = w; flush = 1'b0;
    cyc = 0; done_cyc = -1; stall_cnt = 0; r = '0; dq = '0; wq = 1'b0; st = 1'b1;
    while (cyc < 40) begin
      #1;
      if (done === 1'b1 && !(chained && cyc == 0)) begin
        done_cyc = cyc; r = result; dq = dest_out; wq = wb_en_out; st = stall;
        break;
      end
      stall_cnt += (stall === 1'b1) ? 1 : 0;
      @(posedge clk);
      cyc++;
    end
    checkOutput({tag, " latency"}, longint'(done_cyc), longint'(lat));
    checkOutput({tag, " stall_cycles"}, longint'(stall_cnt), longint'(chained ? lat - 1 : lat));
    checkOutput({tag, " result"}, longint'(r), modelResult(o, a, b));
    checkOutput({tag, " dest_out"}, longint'(dq), longint'(d));
    checkOutput({tag, " wb_en_out"}, longint'(wq), longint'(w));
    checkOutput({tag, " stall_in_done"}, longint'(st), 0);
    if (!keep) begin
      start = 1'b0;
      tick();
      #1;
      checkOutput({tag, " pulse_end"}, longint'({done, busy}), 0);
      tick();
    end
  endtask

  initial begin
    int stall_cnt;
    logic seen_done;
    bit prev_keep;
    bit keep;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; start = 1'b0; op = 2'b00; val1 = '0; val2 = '0;
    dest_in = '0; wb_en_in = 1'b0; flush = 1'b0;
    #3;
    checkOutput("reset_outputs", longint'({stall, busy, done, result, dest_out, wb_en_out}), 0);
    tick();
    rst = 1'b0;
    tick();

    // Directed cases from the test plan.
    applyStimulus("mul7x6",   2'b01, 32'd7,          32'd6, 5'd5,  1'b1, 1'b0, 1'b0);
    applyStimulus("mulwrap",  2'b01, 32'hFFFF_FFFF,  32'd2, 5'd9,  1'b1, 1'b0, 1'b0);
    applyStimulus("divu100",  2'b10, 32'd100,        32'd7, 5'd12, 1'b1, 1'b0, 1'b0);
    applyStimulus("remu100",  2'b11, 32'd100,        32'd7, 5'd13, 1'b0, 1'b0, 1'b0);
    applyStimulus("divu_by0", 2'b10, 32'd55,         32'd0, 5'd20, 1'b1, 1'b0, 1'b0);
    applyStimulus("remu_by0", 2'b11, 32'd55,         32'd0, 5'd21, 1'b1, 1'b0, 1'b0);

    // Back-to-back: DIVU 9/3 presented in the DONE cycle of MUL 5x5.
    applyStimulus("b2b_mul",  2'b01, 32'd5, 32'd5, 5'd3, 1'b1, 1'b0, 1'b1);
    applyStimulus("b2b_div",  2'b10, 32'd9, 32'd3, 5'd4, 1'b1, 1'b1, 1'b0);

    // NOP with start is ignored.
    start = 1'b1; op = 2'b00; val1 = 32'd4; val2 = 32'd4;
    stall_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      stall_cnt += (stall === 1'b1 || busy === 1'b1) ? 1 : 0;
      tick();
    end
    checkOutput("nop_ignored", longint'(stall_cnt), 0);

    // Flush in IDLE blocks start for that cycle.
    op = 2'b01; flush = 1'b1;
    #1;
    checkOutput("idle_flush_stall", longint'(stall), 0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("idle_flush_busy", longint'(busy), 0);
    tick();

    // Flush at cycle 10 of a MUL: idle at cycle 11, no done ever.
    start = 1'b1; op = 2'b01; val1 = 32'd11; val2 = 32'd13; dest_in = 5'd7; wb_en_in = 1'b1;
    stall_cnt = 0; seen_done = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      #1;
      stall_cnt += (stall === 1'b1) ? 1 : 0;
      seen_done |= done;
      if (c == 10) begin
        flush = 1'b1; start = 1'b0;
      end
      tick();
    end
    flush = 1'b0;
    #1;
    checkOutput("flush_stall_cycles", longint'(stall_cnt), 11);
    checkOutput("flush_idle", longint'({busy, stall, done, wb_en_out}), 0);
    for (int c = 0; c < 40; c++) begin
      seen_done |= done;
      tick();
    end
    checkOutput("flush_no_done", longint'(seen_done), 0);

    // Asynchronous reset mid-RUN (cycle 15), then a fresh op.
    start = 1'b1; op = 2'b01; val1 = 32'd21; val2 = 32'd2; dest_in = 5'd30; wb_en_in = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    #1;
    start = 1'b0; rst = 1'b1;
    #1;
    checkOutput("midrun_reset", longint'({stall, busy, done, result, dest_out, wb_en_out}), 0);
    tick();
    rst = 1'b0;
    tick();
    applyStimulus("after_rst", 2'b01, 32'd3, 32'd3, 5'd8, 1'b1, 1'b0, 1'b0);

    // Flush and start together in a DONE cycle: flush wins.
    applyStimulus("pre_flush", 2'b10, 32'd81, 32'd9, 5'd17, 1'b1, 1'b0, 1'b1);
    start = 1'b1; op = 2'b01; val1 = 32'd2; val2 = 32'd2; flush = 1'b1;
    #1;
    checkOutput("done_flush_gate", longint'({done, wb_en_out, stall}), 0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    checkOutput("done_flush_idle", longint'({busy, stall}), 0);
    tick();

    // Randomized ops, some chained back-to-back, some dividing by zero.
    prev_keep = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ro = 2'($urandom_range(1, 3));
      ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      keep = (i < 13) && ($urandom_range(0, 2) == 0);
      applyStimulus($sformatf("rnd%0d", i), ro, ra, rb, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), prev_keep, keep);
      prev_keep = keep;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
